// File: rtl/mem_bus_arbiter_if.sv
// ibus/dbus requester signals and the shared memory port, seen from the core side (master) and the arbiter (slave).
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              ibus_req;
    logic [ADDR_W-1:0] ibus_addr;
    logic [DATA_W-1:0] ibus_rdata;
    logic              ibus_ack;
    logic              ibus_stall;

    logic              dbus_req;
    logic [STRB_W-1:0] dbus_wstrb;
    logic [ADDR_W-1:0] dbus_addr;
    logic [DATA_W-1:0] dbus_wdata;
    logic [DATA_W-1:0] dbus_rdata;
    logic              dbus_ack;
    logic              dbus_stall;

    logic              mem_req;
    logic              mem_wr;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ibus_req, ibus_addr,
        output ibus_rdata, ibus_ack, ibus_stall,
        input  dbus_req, dbus_wstrb, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_ack, dbus_stall,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output ibus_req, ibus_addr,
        input  ibus_rdata, ibus_ack, ibus_stall,
        output dbus_req, dbus_wstrb, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_ack, dbus_stall,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between ibus and dbus, one outstanding transaction; mem_req 1 cycle after req, ack on mem_data_ok.
// Losers stall until served. Define ARB_FAIR_EN to alternate grants under contention (default: fixed dbus-first).
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } owner_t;

    state_t            state_q;
    owner_t            owner_q;
    logic              mem_req_q;
    logic              mem_wr_q;
    logic [STRB_W-1:0] mem_wstrb_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic grant_dbus_d;
    logic complete;

`ifdef ARB_FAIR_EN
    owner_t last_grant_q;

    // Under contention the side that did not win last time goes first.
    assign grant_dbus_d = bus.dbus_req & (~bus.ibus_req | (last_grant_q == OWN_IBUS));
`else
    assign grant_dbus_d = bus.dbus_req;
`endif

    // mem_data_ok only counts while a transaction is open; strays in IDLE are dropped.
    assign complete = bus.mem_data_ok &
                      ((state_q == DATA) | ((state_q == ADDR) & bus.mem_addr_ok));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IBUS;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ARB_FAIR_EN
            last_grant_q <= OWN_IBUS;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ibus_req | bus.dbus_req) begin
                        owner_q     <= grant_dbus_d ? OWN_DBUS : OWN_IBUS;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= grant_dbus_d & (|bus.dbus_wstrb);
                        mem_wstrb_q <= grant_dbus_d ? bus.dbus_wstrb : '0;
                        mem_addr_q  <= grant_dbus_d ? bus.dbus_addr : bus.ibus_addr;
                        mem_wdata_q <= grant_dbus_d ? bus.dbus_wdata : '0;
`ifdef ARB_FAIR_EN
                        last_grant_q <= grant_dbus_d ? OWN_DBUS : OWN_IBUS;
`endif
                        state_q     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state_q   <= bus.mem_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bus.mem_data_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    assign bus.ibus_ack   = complete & (owner_q == OWN_IBUS);
    assign bus.dbus_ack   = complete & (owner_q == OWN_DBUS);
    assign bus.ibus_rdata = bus.mem_rdata;
    assign bus.dbus_rdata = bus.mem_rdata;
    assign bus.ibus_stall = bus.ibus_req & ~bus.ibus_ack;
    assign bus.dbus_stall = bus.dbus_req & ~bus.dbus_ack;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Random and directed traffic on ibus/dbus against a transaction-level model with a scoreboard per requester.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    int errors = 0;
    int checks = 0;

    exp_t ib_q[$];
    exp_t db_q[$];
    bit   grant_log[$];

    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] env_mem [logic [29:0]];

    int ib_left = 0, db_left = 0, gap_max = 0, db_wr_pct = 50;
    bit ib_pend = 0, db_pend = 0, ib_done = 0, db_done = 0;
    bit ib_fix_en = 0, db_fix_en = 0;
    logic [31:0] ib_fix_addr = '0, db_fix_addr = '0, db_fix_wdata = '0;
    logic [3:0]  db_fix_strb = '0;

    int aw_lo = 0, aw_hi = 0, dw_lo = 0, dw_hi = 0, same_pct = 0, stray_pct = 0;
    int cur_aw = 0;
    bit mem_cmpl = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_word(a);
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        if (env_mem.exists(a[31:2])) return env_mem[a[31:2]];
        return init_word(a);
    endfunction

    // ibus requester
    initial begin : ibus_drv
        int gap;
        logic [31:0] a;
        exp_t e;
        gap = 0;
        bus.ibus_req = 1'b0;
        bus.ibus_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.ibus_req = 1'b0; ib_pend = 0; ib_done = 0; gap = 0;
            end else begin
                if (ib_done) begin ib_done = 0; ib_pend = 0; bus.ibus_req = 1'b0; end
                if (!ib_pend && ib_left > 0) begin
                    if (gap > 0) gap--;
                    else begin
                        a = ib_fix_en ? ib_fix_addr : (32'hBFC0_0000 | ($urandom_range(0, 255) << 2));
                        bus.ibus_addr = a;
                        bus.ibus_req = 1'b1;
                        ib_pend = 1; ib_left--;
                        e.chk = 1'b1; e.data = ref_read(a);
                        ib_q.push_back(e);
                        gap = $urandom_range(0, gap_max);
                    end
                end
            end
        end
    end

    // dbus requester; the reference memory is updated in issue order
    initial begin : dbus_drv
        int gap;
        logic [31:0] a, w;
        logic [3:0] s;
        exp_t e;
        gap = 0;
        bus.dbus_req = 1'b0; bus.dbus_addr = '0; bus.dbus_wdata = '0; bus.dbus_wstrb = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.dbus_req = 1'b0; db_pend = 0; db_done = 0; gap = 0;
            end else begin
                if (db_done) begin db_done = 0; db_pend = 0; bus.dbus_req = 1'b0; end
                if (!db_pend && db_left > 0) begin
                    if (gap > 0) gap--;
                    else begin
                        a = db_fix_en ? db_fix_addr : (32'h8000_0000 | ($urandom_range(0, 15) << 2));
                        s = db_fix_en ? db_fix_strb :
                            (($urandom_range(0, 99) < db_wr_pct) ? 4'($urandom_range(1, 15)) : 4'h0);
                        w = db_fix_en ? db_fix_wdata : $urandom;
                        bus.dbus_addr = a; bus.dbus_wstrb = s; bus.dbus_wdata = w;
                        bus.dbus_req = 1'b1;
                        db_pend = 1; db_left--;
                        if (s != 4'h0) begin
                            ref_mem[a[31:2]] = merge(ref_read(a), w, s);
                            e.chk = 1'b0; e.data = '0;
                        end else begin
                            e.chk = 1'b1; e.data = ref_read(a);
                        end
                        db_q.push_back(e);
                        gap = $urandom_range(0, gap_max);
                    end
                end
            end
        end
    end

    // Memory: accepts after cur_aw waiting cycles, completes same cycle or after the data wait
    initial begin : mem_env
        int p, cnt, cur_dw;
        bit cur_same;
        logic [31:0] t_addr, t_wdata;
        logic t_wr;
        logic [3:0] t_strb;
        p = 0; cnt = 0; cur_dw = 0; cur_same = 0;
        t_addr = '0; t_wdata = '0; t_wr = 1'b0; t_strb = '0;
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = $urandom; mem_cmpl = 0;
            if (rst) p = 0;
            else begin
                if (p == 0 && bus.mem_req) begin
                    t_addr = bus.mem_addr; t_wr = bus.mem_wr; t_strb = bus.mem_wstrb; t_wdata = bus.mem_wdata;
                    cur_aw = $urandom_range(aw_lo, aw_hi);
                    cur_dw = $urandom_range(dw_lo, dw_hi);
                    cur_same = ($urandom_range(0, 99) < same_pct);
                    cnt = cur_aw; p = 1;
                end else if (p == 0 && $urandom_range(0, 99) < stray_pct) begin
                    bus.mem_data_ok = 1'b1;
                end
                if (p == 1) begin
                    if (cnt == 0) begin
                        bus.mem_addr_ok = 1'b1;
                        if (cur_same) p = 3; else begin cnt = cur_dw; p = 2; end
                    end else cnt--;
                end else if (p == 2) begin
                    if (cnt == 0) p = 3; else cnt--;
                end
                if (p == 3) begin
                    bus.mem_data_ok = 1'b1; mem_cmpl = 1;
                    if (t_wr) env_mem[t_addr[31:2]] = merge(env_read(t_addr), t_wdata, t_strb);
                    else bus.mem_rdata = env_read(t_addr);
                    p = 0;
                end
            end
        end
    end

    // Monitor: grant rule, timing, field stability, acks against the scoreboards
    initial begin : monitor
        bit busy, owner_d, last_d, prev_free, prev_mreq, prev_aok, prev_ireq, prev_dreq;
        bit grant_now, exp_grant, exp_iack, exp_dack;
        int req_hi;
        logic [68:0] g_fields;
        exp_t e;
        busy = 0; owner_d = 0; last_d = 0; prev_free = 1; prev_mreq = 0; prev_aok = 0;
        prev_ireq = 0; prev_dreq = 0; req_hi = 0; g_fields = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                busy = 0; last_d = 0; prev_free = 1; prev_mreq = 0; prev_aok = 0;
                prev_ireq = 0; prev_dreq = 0;
                ib_q.delete(); db_q.delete();
            end else begin
                grant_now = bus.mem_req && !prev_mreq;
                exp_grant = prev_free && (prev_ireq || prev_dreq);
                check("grant_timing", grant_now, exp_grant);
                if (prev_mreq) check("mem_req_until_addr_ok", bus.mem_req, !prev_aok);
                if (grant_now) begin
`ifdef ARB_FAIR_EN
                    owner_d = prev_dreq && (!prev_ireq || !last_d);
`else
                    owner_d = prev_dreq;
`endif
                    last_d = owner_d; busy = 1; req_hi = 0;
                    grant_log.push_back(bus.mem_addr[31:28] != 4'hB);
                    if (owner_d)
                        check("grant_dbus_fields", {bus.mem_addr, bus.mem_wr, bus.mem_wstrb, bus.mem_wdata},
                              {bus.dbus_addr, |bus.dbus_wstrb, bus.dbus_wstrb, bus.dbus_wdata});
                    else
                        check("grant_ibus_fields", {bus.mem_addr, bus.mem_wr, bus.mem_wstrb},
                              {bus.ibus_addr, 1'b0, 4'h0});
                    g_fields = {bus.mem_addr, bus.mem_wr, bus.mem_wstrb, bus.mem_wdata};
                end else if (bus.mem_req) begin
                    check("fields_stable", {bus.mem_addr, bus.mem_wr, bus.mem_wstrb, bus.mem_wdata}, g_fields);
                end
                if (bus.mem_req) req_hi++;
                if (bus.mem_req && bus.mem_addr_ok) check("mem_req_cycles", req_hi, cur_aw + 1);
                exp_iack = mem_cmpl && busy && !owner_d;
                exp_dack = mem_cmpl && busy && owner_d;
                check("ibus_ack", bus.ibus_ack, exp_iack);
                check("dbus_ack", bus.dbus_ack, exp_dack);
                check("ibus_stall", bus.ibus_stall, bus.ibus_req && !exp_iack);
                check("dbus_stall", bus.dbus_stall, bus.dbus_req && !exp_dack);
                if (bus.ibus_ack) begin
                    if (ib_q.size() == 0) check("ibus_ack_unexpected", 1, 0);
                    else begin
                        e = ib_q.pop_front();
                        if (e.chk) check("ibus_rdata", bus.ibus_rdata, e.data);
                    end
                    ib_done = 1;
                end
                if (bus.dbus_ack) begin
                    if (db_q.size() == 0) check("dbus_ack_unexpected", 1, 0);
                    else begin
                        e = db_q.pop_front();
                        if (e.chk) check("dbus_rdata", bus.dbus_rdata, e.data);
                    end
                    db_done = 1;
                end
                prev_free = !busy;
                if (mem_cmpl) busy = 0;
                prev_mreq = bus.mem_req; prev_aok = bus.mem_addr_ok;
                prev_ireq = bus.ibus_req; prev_dreq = bus.dbus_req;
            end
        end
    end

    task automatic wait_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(ib_left == 0 && db_left == 0 && !ib_pend && !db_pend)) begin
            @(posedge clk); n++;
        end
        check({tag, "_completes"}, n < budget, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic set_mem(input int al, input int ah, input int dl, input int dh, input int sp, input int st);
        aw_lo = al; aw_hi = ah; dw_lo = dl; dw_hi = dh; same_pct = sp; stray_pct = st;
    endtask

    initial begin : main
        logic [7:0] order, exp_order;
        int n;
        ref_mem[30'h2FF0_0000] = 32'h3C08_0001;
        env_mem[30'h2FF0_0000] = 32'h3C08_0001;

        repeat (3) @(posedge clk); #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_wstrb", bus.mem_wstrb, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_acks", {bus.ibus_ack, bus.dbus_ack}, 0);
        #2 rst = 1'b0;

        // Zero-wait ibus fetch of the reset vector
        set_mem(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ib_fix_en = 1; ib_fix_addr = 32'hBFC0_0000; ib_left = 1;
        wait_quiet("t1_fetch", 50);
        ib_fix_en = 0;

        // Simultaneous requests held over four transactions each
        @(negedge clk);
        grant_log.delete();
        gap_max = 0; db_wr_pct = 0; ib_left = 4; db_left = 4;
        wait_quiet("contention", 400);
`ifdef ARB_FAIR_EN
        exp_order = 8'b1010_1010;
`else
        exp_order = 8'b1111_0000;
`endif
        order = '0;
        for (int i = 0; i < 8 && i < grant_log.size(); i++) order[7-i] = grant_log[i];
        check("grant_count", grant_log.size(), 8);
        check("grant_order", order, exp_order);

        // dbus half-word store then read back
        set_mem(2, 2, 1, 1, 0, 0);
        @(negedge clk);
        db_fix_en = 1; db_fix_addr = 32'h8000_0010; db_fix_strb = 4'b0011; db_fix_wdata = 32'hDEAD_BEEF;
        db_left = 1;
        wait_quiet("t2_store", 50);
        @(negedge clk);
        db_fix_strb = 4'b0000; db_left = 1;
        wait_quiet("t2_load", 50);
        db_fix_en = 0;

        // Slow address acceptance, then same-cycle accept and complete
        set_mem(3, 3, 1, 1, 0, 0);
        @(negedge clk); ib_left = 1;
        wait_quiet("t5_slow", 50);
        set_mem(0, 0, 0, 0, 100, 0);
        @(negedge clk); ib_left = 1; db_left = 1;
        wait_quiet("t6_same_cycle", 50);

        // Reset while the address phase is open
        set_mem(6, 6, 0, 0, 0, 0);
        @(negedge clk); ib_left = 1;
        n = 0;
        while (!bus.mem_req && n < 20) begin @(posedge clk); #1; n++; end
        check("rst_test_granted", bus.mem_req, 1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("async_rst_mem_req", bus.mem_req, 0);
        check("async_rst_acks", {bus.ibus_ack, bus.dbus_ack}, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("post_rst_idle", bus.mem_req, 0);

        // Random traffic with stray data_ok in idle
        set_mem(0, 3, 0, 3, 30, 10);
        @(negedge clk);
        gap_max = 3; db_wr_pct = 40; ib_left = 60; db_left = 60;
        wait_quiet("random_gaps", 4000);
        @(negedge clk);
        gap_max = 0; ib_left = 40; db_left = 40;
        wait_quiet("random_busy", 4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
